// File: rtl/apu_pulse_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : apu_pulse_mixer
//  Purpose  : Collects one 1-bit level from each APU pulse channel per round
//             (valid/ready), weights each level by a per-channel volume,
//             sums them into a mixed sample and turns that sample into a
//             1-bit PDM pin with a first-order sigma-delta modulator.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             clock
//    rst_n           asynchronous active-low reset
//    i_ch_data       pulse level per channel
//    i_ch_vld        per-channel valid
//    o_ch_rdy        per-channel ready (registered state only, no vld->rdy path)
//    i_vol_data      volume value to write
//    i_vol_sel       target channel index (>= NUM_CH: accepted and dropped)
//    i_vol_vld       volume write valid
//    o_vol_rdy       volume write ready (1 from first edge after reset)
//    i_div           idle cycles between sample collections
//    i_mute          (only with APU_MIXER_MUTE_EN) force sample and PDM to 0
//    o_sample_out    last mixed sample
//    o_sample_strobe one-cycle pulse when o_sample_out updates
//    o_pdm_out       sigma-delta output bit
//  Optional feature macro: APU_MIXER_MUTE_EN (adds i_mute)
// ============================================================================
module apu_pulse_mixer #(
    parameter int NUM_CH = 3,
    parameter int VOL_W  = 4,
    parameter int DIV_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    i_ch_data,
    input  logic [NUM_CH-1:0]    i_ch_vld,
    output logic [NUM_CH-1:0]    o_ch_rdy,
    input  logic [VOL_W-1:0]     i_vol_data,
    input  logic [1:0]           i_vol_sel,
    input  logic                 i_vol_vld,
    output logic                 o_vol_rdy,
    input  logic [DIV_W-1:0]     i_div,
`ifdef APU_MIXER_MUTE_EN
    input  logic                 i_mute,
`endif
    output logic [VOL_W+1:0]     o_sample_out,
    output logic                 o_sample_strobe,
    output logic                 o_pdm_out
);

    localparam int SUM_W = VOL_W + 2;
    localparam logic [NUM_CH-1:0] c_ALL_GOT = '1;

    typedef enum logic [0:0] {
        S_WAIT    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DIV_W-1:0]       r_cnt;
    logic [DIV_W-1:0]       w_cnt_nxt;
    logic [NUM_CH-1:0]      r_got;
    logic [NUM_CH-1:0]      r_bits;
    logic [VOL_W-1:0]       r_vol [NUM_CH];
    logic                   r_vol_rdy;
    logic [SUM_W-1:0]       r_sample;
    logic                   r_strobe;
    logic [SUM_W:0]         r_acc;
    logic                   r_pdm;

    logic [NUM_CH-1:0]      w_take;
    logic [NUM_CH-1:0]      w_got_nxt;
    logic [NUM_CH-1:0]      w_bits_nxt;
    logic                   w_done;
    logic [SUM_W-1:0]       w_sum;
    logic [SUM_W:0]         w_acc_nxt;
    logic                   w_mute;

`ifdef APU_MIXER_MUTE_EN
    assign w_mute = i_mute;
`else
    assign w_mute = 1'b0;
`endif

    // Ready comes purely from registered state so the upstream channel never
    // sees a combinational path from its own valid back to ready.
    assign o_ch_rdy   = (r_state == S_COLLECT) ? ~r_got : '0;
    assign w_take     = i_ch_vld & o_ch_rdy;
    assign w_got_nxt  = r_got | w_take;
    assign w_bits_nxt = (r_bits & ~w_take) | (i_ch_data & w_take);

    // ------------------------------------------------------------------
    // Round state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_COLLECT;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_COLLECT: begin
                // Round closes on the edge where the last missing channel lands;
                // i_div is only sampled here, so mid-wait changes wait a round.
                if (w_got_nxt == c_ALL_GOT) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = i_div;
                end
            end
            default: w_state_nxt = S_WAIT;
        endcase
    end

    // Weighted sum of the round's levels using the pre-write volume values.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_bits_nxt[i]) begin
                w_sum = w_sum + SUM_W'(r_vol[i]);
            end
        end
    end

    // Carry out of the SUM_W-bit accumulator is the PDM bit.
    assign w_acc_nxt = {1'b0, r_acc[SUM_W-1:0]} + {1'b0, r_sample};

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_got     <= '0;
            r_bits    <= '0;
            r_vol_rdy <= 1'b0;
            r_sample  <= '0;
            r_strobe  <= 1'b0;
            r_acc     <= '0;
            r_pdm     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_vol[i] <= '1;
            end
        end else begin
            r_vol_rdy <= 1'b1;
            r_strobe  <= w_done;
            r_bits    <= w_bits_nxt;
            r_got     <= w_done ? '0 : w_got_nxt;

            if (w_done) begin
                r_sample <= w_mute ? '0 : w_sum;
            end

            if (w_mute) begin
                r_acc <= '0;
                r_pdm <= 1'b0;
            end else begin
                r_acc <= w_acc_nxt;
                r_pdm <= w_acc_nxt[SUM_W];
            end

            // Out-of-range selects match no channel: accepted and dropped.
            if (i_vol_vld && r_vol_rdy) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (i_vol_sel == 2'(i)) begin
                        r_vol[i] <= i_vol_data;
                    end
                end
            end
        end
    end

    assign o_vol_rdy       = r_vol_rdy;
    assign o_sample_out    = r_sample;
    assign o_sample_strobe = r_strobe;
    assign o_pdm_out       = r_pdm;

endmodule
`default_nettype wire
